// File: rtl/pdh_cmd_responder.sv
// PS<->core GPIO command responder: resynchronises the PS word, executes register accesses on a
// request toggle and echoes the toggle as ack. Optional watchdog enabled by PDH_CMD_WDOG_EN.
module pdh_cmd_responder #(
    parameter int unsigned NUM_RW        = 8,
    parameter int unsigned NUM_RO        = 4,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT    = 125000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            axi_from_ps_i,
    output logic [31:0]            axi_to_ps_o,
    output logic [NUM_RW*24-1:0]   cfg_o,
    output logic [NUM_RW-1:0]      cfg_wr_o,
    input  logic [NUM_RO*24-1:0]   status_i,
    output logic                   busy_o,
    output logic                   wdog_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StExec} state_e;

    state_e state_q, state_d;

    logic [31:0]             s1_q, s2_q;
    logic [31:0]             cap_q, cap_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    last_tog_q;
    logic [31:0]             resp_q;
    logic [NUM_RW-1:0][23:0] cfg_q;
    logic [NUM_RW-1:0]       cfg_wr_q;

    logic              pending;
    logic              exec;
    logic              is_wr;
    logic [5:0]        addr;
    logic              hit_rw;
    logic              hit_ro;
    logic              err;
    logic [23:0]       rd_data;
    logic [23:0]       resp_data;
    logic [NUM_RW-1:0] wr_sel;
    logic              wdog_fire;

    assign pending = (s2_q[31] != last_tog_q);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pending) begin
                    cap_d   = s2_q;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (s2_q == cap_q) begin
                    if (cnt_q == 4'(STABLE_CYCLES - 1)) begin
                        state_d = StExec;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (s2_q[31] == last_tog_q) begin
                    // Toggle reverted before the word settled: drop the request.
                    state_d = StIdle;
                end else begin
                    cap_d = s2_q;
                    cnt_d = '0;
                end
            end
            StExec: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output / access decode
    always_comb begin
        busy_o  = (state_q != StIdle);
        exec    = (state_q == StExec);
        is_wr   = cap_q[30];
        addr    = cap_q[29:24];
        hit_rw  = 1'b0;
        hit_ro  = 1'b0;
        rd_data = '0;
        wr_sel  = '0;
        for (int k = 0; k < int'(NUM_RW); k++) begin
            if (addr == k[5:0]) begin
                hit_rw  = 1'b1;
                rd_data = cfg_q[k];
            end
        end
        for (int k = 0; k < int'(NUM_RO); k++) begin
            if (addr == 6'(int'(NUM_RW) + k)) begin
                hit_ro  = 1'b1;
                rd_data = status_i[24*k +: 24];
            end
        end
        err = !(hit_rw || (hit_ro && !is_wr));
        if (err) begin
            resp_data = '0;
        end else if (is_wr) begin
            resp_data = cap_q[23:0];
        end else begin
            resp_data = rd_data;
        end
        for (int k = 0; k < int'(NUM_RW); k++) begin
            if (exec && is_wr && hit_rw && (addr == k[5:0])) begin
                wr_sel[k] = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            last_tog_q <= 1'b0;
            resp_q     <= '0;
            cfg_q      <= '0;
            cfg_wr_q   <= '0;
        end else begin
            s1_q     <= axi_from_ps_i;
            s2_q     <= s1_q;
            cfg_wr_q <= wr_sel | NUM_RW'(wdog_fire);
            if (exec) begin
                resp_q     <= {cap_q[31], err, addr, resp_data};
                last_tog_q <= cap_q[31];
            end
            for (int k = 0; k < int'(NUM_RW); k++) begin
                if (wr_sel[k]) begin
                    cfg_q[k] <= cap_q[23:0];
                end
            end
            if (wdog_fire) begin
                cfg_q[0][0] <= 1'b0;
            end
        end
    end

`ifdef PDH_CMD_WDOG_EN
    logic [31:0] wdog_cnt_q;
    logic        wdog_q;

    // Fires once when the counter reaches the limit; saturation prevents refiring.
    assign wdog_fire = !exec && (wdog_cnt_q == 32'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            if (exec) begin
                wdog_cnt_q <= '0;
            end else if (wdog_cnt_q != 32'(WDOG_LIMIT)) begin
                wdog_cnt_q <= wdog_cnt_q + 32'd1;
            end
            if (wdog_fire) begin
                wdog_q <= 1'b1;
            end else if (exec && is_wr && !err) begin
                wdog_q <= 1'b0;
            end
        end
    end

    assign wdog_o = wdog_q;
`else
    logic unused_wdog_limit;

    assign unused_wdog_limit = ^WDOG_LIMIT;
    assign wdog_fire         = 1'b0;
    assign wdog_o            = 1'b0;
`endif

    assign axi_to_ps_o = resp_q;
    assign cfg_o       = cfg_q;
    assign cfg_wr_o    = cfg_wr_q;

endmodule

// File: tb/tb_pdh_cmd_responder.sv
// Directed self-checking bench for pdh_cmd_responder (default parameters, watchdog limit 100).
module tb_pdh_cmd_responder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  axi_from_ps_i;
    logic [31:0]  axi_to_ps_o;
    logic [191:0] cfg_o;
    logic [7:0]   cfg_wr_o;
    logic [95:0]  status_i;
    logic         busy_o;
    logic         wdog_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [191:0] exp_cfg;
    logic         ok;

    pdh_cmd_responder #(
        .NUM_RW        (8),
        .NUM_RO        (4),
        .STABLE_CYCLES (2),
        .WDOG_LIMIT    (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axi_from_ps_i (axi_from_ps_i),
        .axi_to_ps_o   (axi_to_ps_o),
        .cfg_o         (cfg_o),
        .cfg_wr_o      (cfg_wr_o),
        .status_i      (status_i),
        .busy_o        (busy_o),
        .wdog_o        (wdog_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a word before edge 1 and stop just after edge 4+STABLE_CYCLES.
    task automatic do_cmd(input logic [31:0] word);
        axi_from_ps_i = word;
        tick(6);
    endtask

    task automatic wait_ack(input logic tog, output logic done);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                tick(1);
                if (axi_to_ps_o[31] == tog) done = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        axi_from_ps_i = 32'h0;
        status_i      = {24'hBBBBBB, 24'hAAAAAA, 24'h999999, 24'h123456};
        exp_cfg       = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_resp", axi_to_ps_o, 0);
        check("rst_cfg", cfg_o, 0);
        check("rst_cfg_wr", cfg_wr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wdog", wdog_o, 0);

        // Write 0xABCDEF to address 1 with latency tracking
        axi_from_ps_i = 32'hC1ABCDEF;
        tick(2);
        check("wr1_busy_e2", busy_o, 0);
        tick(1);
        check("wr1_busy_e3", busy_o, 1);
        tick(2);
        check("wr1_busy_e5", busy_o, 1);
        check("wr1_resp_e5", axi_to_ps_o, 0);
        tick(1);
        exp_cfg[47:24] = 24'hABCDEF;
        check("wr1_resp", axi_to_ps_o, 32'h81ABCDEF);
        check("wr1_cfg", cfg_o, exp_cfg);
        check("wr1_cfg_wr", cfg_wr_o, 8'h02);
        check("wr1_busy_e6", busy_o, 0);
        tick(1);
        check("wr1_cfg_wr_end", cfg_wr_o, 8'h00);

        // Read status address 8
        do_cmd(32'h08000000);
        check("rd8_resp", axi_to_ps_o, 32'h08123456);
        check("rd8_cfg_wr", cfg_wr_o, 0);
        tick(1);

        // Read back config register 1
        do_cmd(32'h81000000);
        check("rd1_resp", axi_to_ps_o, 32'h81ABCDEF);
        tick(1);

        // Write to read-only address 8
        do_cmd(32'h48000055);
        check("wr8_resp", axi_to_ps_o, 32'h48000000);
        check("wr8_cfg", cfg_o, exp_cfg);
        check("wr8_cfg_wr", cfg_wr_o, 0);
        tick(1);

        // Read unmapped address 63
        do_cmd(32'hBF000000);
        check("rd63_resp", axi_to_ps_o, 32'hFF000000);
        check("rd63_cfg", cfg_o, exp_cfg);
        tick(1);

        // Glitch to address 3 for one cycle during SETTLE, settle on address 4
        axi_from_ps_i = 32'h42111111;
        tick(2);
        axi_from_ps_i = 32'h43333333;
        tick(1);
        check("glitch_busy", busy_o, 1);
        axi_from_ps_i = 32'h44444444;
        wait_ack(1'b0, ok);
        check("glitch_ack_seen", ok, 1);
        exp_cfg[119:96] = 24'h444444;
        check("glitch_resp", axi_to_ps_o, 32'h04444444);
        check("glitch_cfg", cfg_o, exp_cfg);
        tick(2);

        // Toggle reverted during SETTLE: no ack, no write
        axi_from_ps_i = 32'hC5555555;
        tick(2);
        axi_from_ps_i = 32'h45555555;
        tick(1);
        check("revert_busy", busy_o, 1);
        tick(2);
        check("revert_idle", busy_o, 0);
        tick(8);
        check("revert_resp", axi_to_ps_o, 32'h04444444);
        check("revert_cfg", cfg_o, exp_cfg);

        // Reset at cycle 4 of a write
        axi_from_ps_i = 32'hC6666666;
        tick(4);
        rst_n         = 1'b0;
        axi_from_ps_i = 32'h0;
        tick(2);
        check("rstmid_resp", axi_to_ps_o, 0);
        check("rstmid_cfg", cfg_o, 0);
        check("rstmid_busy", busy_o, 0);
        rst_n = 1'b1;
        tick(8);
        check("rstpost_resp", axi_to_ps_o, 0);
        check("rstpost_cfg", cfg_o, 0);
        check("rstpost_busy", busy_o, 0);
        check("rstpost_cfg_wr", cfg_wr_o, 0);

`ifdef PDH_CMD_WDOG_EN
        exp_cfg = '0;
        do_cmd(32'hC0000001);
        exp_cfg[23:0] = 24'h000001;
        check("wd_wr_resp", axi_to_ps_o, 32'h80000001);
        check("wd_wr_cfg", cfg_o, exp_cfg);
        axi_from_ps_i = 32'h80000001;
        tick(99);
        check("wd_pre_cfg", cfg_o, exp_cfg);
        check("wd_pre_flag", wdog_o, 0);
        tick(1);
        exp_cfg[23:0] = 24'h000000;
        check("wd_fire_cfg", cfg_o, exp_cfg);
        check("wd_fire_flag", wdog_o, 1);
        check("wd_fire_cfg_wr", cfg_wr_o, 8'h01);
        tick(1);
        do_cmd(32'h41000007);
        exp_cfg[47:24] = 24'h000007;
        check("wd_clr_resp", axi_to_ps_o, 32'h01000007);
        check("wd_clr_flag", wdog_o, 0);
        check("wd_clr_cfg", cfg_o, exp_cfg);
`else
        check("nowd_flag", wdog_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
